// File: rtl/mandel_pkg.sv
// Shared definitions for the Mandelbrot core and its pixel scheduler.
// Keeping the fixed-point width and iteration limit here stops the two
// blocks from being built with mismatched defaults.
package mandel_pkg;

    localparam int MANDEL_FIXED_POINT_WIDTH = 16;
    localparam int MANDEL_MAX_ITER          = 256;

    typedef logic [2:0] state_t;

    localparam state_t IDLE   = 3'd0;
    localparam state_t LAUNCH = 3'd1;
    localparam state_t SETTLE = 3'd2;
    localparam state_t WAIT   = 3'd3;
    localparam state_t OUT    = 3'd4;

endpackage

// File: rtl/mandel_coord_gen.sv
// Raster-order pixel counter with incremental fixed-point c generation.
// c_real steps right by +step, c_imag steps down by -step; no multiplier.
module mandel_coord_gen
    import mandel_pkg::*;
#(
    parameter int H_RES             = 320,
    parameter int V_RES             = 240,
    parameter int FIXED_POINT_WIDTH = MANDEL_FIXED_POINT_WIDTH
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         load,
    input  logic                         advance,
    input  logic [FIXED_POINT_WIDTH-1:0] x_origin,
    input  logic [FIXED_POINT_WIDTH-1:0] y_origin,
    input  logic [FIXED_POINT_WIDTH-1:0] step,
    output logic [$clog2(H_RES)-1:0]     x,
    output logic [$clog2(V_RES)-1:0]     y,
    output logic [FIXED_POINT_WIDTH-1:0] c_real,
    output logic [FIXED_POINT_WIDTH-1:0] c_imag,
    output logic                         last_col,
    output logic                         last_pixel
);

    localparam int XW = $clog2(H_RES);
    localparam int YW = $clog2(V_RES);

    logic [FIXED_POINT_WIDTH-1:0] org_real;
    logic [FIXED_POINT_WIDTH-1:0] step_r;

    assign last_col   = (x == XW'(H_RES - 1));
    assign last_pixel = last_col && (y == YW'(V_RES - 1));

    // Latch the frame parameters on load, then walk the raster on each advance.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            org_real <= '0;
            step_r   <= '0;
            x        <= '0;
            y        <= '0;
            c_real   <= '0;
            c_imag   <= '0;
        end else if (load) begin
            org_real <= x_origin;
            step_r   <= step;
            x        <= '0;
            y        <= '0;
            c_real   <= x_origin;
            c_imag   <= y_origin;
        end else if (advance) begin
            if (last_col) begin
                x      <= '0;
                y      <= y + YW'(1);
                c_real <= org_real;
                c_imag <= c_imag - step_r;
            end else begin
                x      <= x + XW'(1);
                c_real <= c_real + step_r;
            end
        end
    end

endmodule

// File: rtl/mandel_pixel_scheduler.sv
// Frame walker around the Mandelbrot core: one pixel in flight, result
// presented on a valid/ready stream as {x, y, iterations, in_set}.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  IDLE   | no frame; waits for go
//  LAUNCH | core_start pulse for the current pixel
//  SETTLE | core_valid may still be stale from last pixel; ignored
//  WAIT   | waits for core_valid, captures the result
//  OUT    | pix_valid held until pix_ready, then next pixel or done
module mandel_pixel_scheduler
    import mandel_pkg::*;
#(
    parameter int H_RES             = 320,
    parameter int V_RES             = 240,
    parameter int FIXED_POINT_WIDTH = MANDEL_FIXED_POINT_WIDTH,
    parameter int MAX_ITER          = MANDEL_MAX_ITER
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         go,
    input  logic                         abort,
    input  logic [FIXED_POINT_WIDTH-1:0] x_origin,
    input  logic [FIXED_POINT_WIDTH-1:0] y_origin,
    input  logic [FIXED_POINT_WIDTH-1:0] step,
    output logic                         core_start,
    output logic [FIXED_POINT_WIDTH-1:0] core_c_real,
    output logic [FIXED_POINT_WIDTH-1:0] core_c_imag,
    input  logic                         core_valid,
    input  logic                         core_is_mandelbrot,
    input  logic [$clog2(MAX_ITER)-1:0]  core_iterations,
    output logic                         pix_valid,
    input  logic                         pix_ready,
    output logic [$clog2(H_RES)-1:0]     pix_x,
    output logic [$clog2(V_RES)-1:0]     pix_y,
    output logic [$clog2(MAX_ITER)-1:0]  pix_iter,
    output logic                         pix_in_set,
    output logic                         busy,
    output logic                         frame_done
);

    state_t state;

    logic [$clog2(H_RES)-1:0] x;
    logic [$clog2(V_RES)-1:0] y;
    logic                     last_col;
    logic                     last_pixel;
    logic                     load;
    logic                     advance;
    logic                     accept;

    assign accept     = (state == OUT) && pix_ready;
    assign load       = (state == IDLE) && go && !abort;
    assign advance    = accept && !last_pixel && !abort;

    assign core_start = (state == LAUNCH);
    assign pix_valid  = (state == OUT);
    assign busy       = (state != IDLE);

    mandel_coord_gen #(
        .H_RES             (H_RES),
        .V_RES             (V_RES),
        .FIXED_POINT_WIDTH (FIXED_POINT_WIDTH)
    ) u_coord_gen (
        .clk        (clk),
        .nrst       (nrst),
        .load       (load),
        .advance    (advance),
        .x_origin   (x_origin),
        .y_origin   (y_origin),
        .step       (step),
        .x          (x),
        .y          (y),
        .c_real     (core_c_real),
        .c_imag     (core_c_imag),
        .last_col   (last_col),
        .last_pixel (last_pixel)
    );

    // Sequencer; abort overrides every transition.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else if (abort) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (go) state <= LAUNCH;
                LAUNCH:  state <= SETTLE;
                SETTLE:  state <= WAIT;
                WAIT:    if (core_valid) state <= OUT;
                OUT:     if (pix_ready) state <= last_pixel ? IDLE : LAUNCH;
                default: state <= IDLE;
            endcase
        end
    end

    // Capture the core result and its pixel position; held through OUT.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pix_x      <= '0;
            pix_y      <= '0;
            pix_iter   <= '0;
            pix_in_set <= 1'b0;
        end else if ((state == WAIT) && core_valid && !abort) begin
            pix_x      <= x;
            pix_y      <= y;
            pix_iter   <= core_iterations;
            pix_in_set <= core_is_mandelbrot;
        end
    end

    // One-cycle pulse after the final pixel of the frame is accepted.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= accept && last_col && last_pixel && !abort;
        end
    end

endmodule

// File: tb/tb_mandel_pixel_scheduler.sv
// Scoreboard bench for mandel_pixel_scheduler on a 4x2 frame with a
// behavioural core of programmable latency and optional stale valid.
module tb_mandel_pixel_scheduler;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int W  = 16;
    localparam int IW = 8;

    logic          clk = 1'b0;
    logic          nrst;
    logic          go, abort;
    logic [W-1:0]  x_origin, y_origin, step;
    logic          core_start;
    logic [W-1:0]  core_c_real, core_c_imag;
    logic          core_valid, core_is_mandelbrot;
    logic [IW-1:0] core_iterations;
    logic          pix_valid, pix_ready;
    logic [1:0]    pix_x;
    logic [0:0]    pix_y;
    logic [IW-1:0] pix_iter;
    logic          pix_in_set, busy, frame_done;

    always #5 clk = ~clk;

    mandel_pixel_scheduler #(
        .H_RES (H), .V_RES (V), .FIXED_POINT_WIDTH (W), .MAX_ITER (256)
    ) dut (
        .clk (clk), .nrst (nrst), .go (go), .abort (abort),
        .x_origin (x_origin), .y_origin (y_origin), .step (step),
        .core_start (core_start), .core_c_real (core_c_real), .core_c_imag (core_c_imag),
        .core_valid (core_valid), .core_is_mandelbrot (core_is_mandelbrot),
        .core_iterations (core_iterations),
        .pix_valid (pix_valid), .pix_ready (pix_ready), .pix_x (pix_x), .pix_y (pix_y),
        .pix_iter (pix_iter), .pix_in_set (pix_in_set), .busy (busy), .frame_done (frame_done)
    );

    typedef struct packed {
        logic [1:0]    x;
        logic [0:0]    y;
        logic [IW-1:0] iter;
        logic          in_set;
    } pix_t;

    pix_t q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural core: valid forced to the stale value at start, real result after lat cycles.
    int            lat   = 3;
    bit            stale = 1'b0;
    int            cnt;
    logic [IW-1:0] model_iter = '0;
    logic          model_set  = 1'b0;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            core_valid         <= 1'b0;
            core_iterations    <= '0;
            core_is_mandelbrot <= 1'b0;
            cnt                <= 0;
        end else if (core_start) begin
            core_valid         <= stale;
            core_iterations    <= stale ? 8'd99 : 8'd0;
            core_is_mandelbrot <= stale ? ~model_set : 1'b0;
            cnt                <= lat;
        end else if (cnt != 0) begin
            cnt        <= cnt - 1;
            core_valid <= (cnt == 1);
            if (cnt == 1) begin
                core_iterations    <= model_iter;
                core_is_mandelbrot <= model_set;
            end
        end
    end

    // Monitor / scoreboard, sampled on the falling edge.
    bit         idle_exp = 1'b1;
    bit         fd_due   = 1'b0;
    int         exp_x = 0, exp_y = 0, pix_cnt = 0, starts = 0;
    logic [W-1:0] fxo = '0, fyo = '0, fst = '0;
    logic [W-1:0] er, ei;
    pix_t       e;

    always @(negedge clk) begin
        if (nrst) begin
            chk("busy", 32'(busy), 32'(!idle_exp));
            chk("frame_done", 32'(frame_done), 32'(fd_due));
            fd_due = 1'b0;
            if (idle_exp) chk("idle_pix_valid", 32'(pix_valid), 0);

            if (core_start) begin
                er = fxo + W'(exp_x) * fst;
                ei = fyo - W'(exp_y) * fst;
                chk("core_c_real", 32'(core_c_real), 32'(er));
                chk("core_c_imag", 32'(core_c_imag), 32'(ei));
                e.x      = 2'(exp_x);
                e.y      = 1'(exp_y);
                e.iter   = IW'(37 + 11 * pix_cnt);
                e.in_set = e.iter[0];
                model_iter = e.iter;
                model_set  = e.in_set;
                q.push_back(e);
                pix_cnt++;
                starts++;
                if (exp_x == H - 1) begin
                    exp_x = 0;
                    exp_y++;
                end else begin
                    exp_x++;
                end
            end

            if (pix_valid) begin
                if (q.size() == 0) begin
                    chk("pix_unexpected", 32'(pix_valid), 0);
                end else if (pix_ready) begin
                    e = q.pop_front();
                    chk("pix_x", 32'(pix_x), 32'(e.x));
                    chk("pix_y", 32'(pix_y), 32'(e.y));
                    chk("pix_iter", 32'(pix_iter), 32'(e.iter));
                    chk("pix_in_set", 32'(pix_in_set), 32'(e.in_set));
                    if (e.x == 2'(H - 1) && e.y == 1'(V - 1)) begin
                        fd_due   = 1'b1;
                        idle_exp = 1'b1;
                    end
                end else begin
                    chk("hold_pix_x", 32'(pix_x), 32'(q[0].x));
                    chk("hold_pix_y", 32'(pix_y), 32'(q[0].y));
                    chk("hold_pix_iter", 32'(pix_iter), 32'(q[0].iter));
                    chk("hold_core_start", 32'(core_start), 0);
                end
            end

            if (abort) begin
                q.delete();
                fd_due   = 1'b0;
                idle_exp = 1'b1;
            end else if (go && idle_exp) begin
                fxo = x_origin;
                fyo = y_origin;
                fst = step;
                exp_x = 0;
                exp_y = 0;
                starts = 0;
                idle_exp = 1'b0;
            end
        end
    end

    task automatic start_frame(input logic [W-1:0] xo, input logic [W-1:0] yo, input logic [W-1:0] st);
        @(posedge clk); #1;
        x_origin = xo;
        y_origin = yo;
        step     = st;
        go       = 1'b1;
        @(posedge clk); #1;
        go       = 1'b0;
        x_origin = ~xo;
        y_origin = ~yo;
        step     = st + 16'd3;
    endtask

    task automatic run_pixels(input int n, input int hold_idx, input int hold_len);
        bit ok;
        for (int i = 0; i < n; i++) begin
            ok = 1'b0;
            for (int t = 0; t < 300; t++) begin
                if (pix_valid) begin
                    ok = 1'b1;
                    break;
                end
                @(posedge clk); #1;
            end
            if (!ok) begin
                chk("pix_timeout", 0, 1);
                return;
            end
            if (i == hold_idx) repeat (hold_len) begin
                @(posedge clk); #1;
            end
            pix_ready = 1'b1;
            @(posedge clk); #1;
            pix_ready = 1'b0;
        end
    endtask

    task automatic end_of_frame();
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("start_count", 32'(starts), 8);
        chk("idle_after_frame", 32'(busy), 0);
    endtask

    initial begin
        nrst = 1'b0; go = 1'b0; abort = 1'b0; pix_ready = 1'b0;
        x_origin = '0; y_origin = '0; step = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pix_valid", 32'(pix_valid), 0);
        chk("rst_core_start", 32'(core_start), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_pix_x", 32'(pix_x), 0);
        chk("rst_pix_y", 32'(pix_y), 0);
        chk("rst_pix_iter", 32'(pix_iter), 0);
        chk("rst_pix_in_set", 32'(pix_in_set), 0);
        chk("rst_c_real", 32'(core_c_real), 0);
        chk("rst_c_imag", 32'(core_c_imag), 0);
        nrst = 1'b1;

        // Plain frame: -2.0 + 1.0i origin, 0.5 step.
        lat = 3; stale = 1'b0;
        start_frame(16'hE000, 16'h1000, 16'h0800);
        run_pixels(8, -1, 0);
        end_of_frame();

        // Stale valid during SETTLE, backpressure on pixel (2,1).
        lat = 2; stale = 1'b1;
        start_frame(16'hE000, 16'h1000, 16'h0800);
        run_pixels(8, 6, 20);
        end_of_frame();

        // Abort during WAIT of pixel (1,0).
        lat = 5; stale = 1'b0;
        start_frame(16'hF000, 16'h0800, 16'h0400);
        run_pixels(1, -1, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_pix_valid", 32'(pix_valid), 0);
        chk("abort_core_start", 32'(core_start), 0);
        repeat (10) begin
            @(posedge clk); #1;
        end

        // go and abort together: stays idle.
        x_origin = 16'h1111;
        go = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        go = 1'b0; abort = 1'b0;
        chk("go_abort_busy", 32'(busy), 0);
        repeat (2) begin
            @(posedge clk); #1;
        end

        // Restart after abort with a fresh origin.
        lat = 1;
        start_frame(16'hF000, 16'hF800, 16'h0400);
        run_pixels(8, -1, 0);
        end_of_frame();

        // go mid-frame with a different origin is ignored.
        lat = 2;
        start_frame(16'h0100, 16'h0200, 16'h0080);
        run_pixels(3, -1, 0);
        x_origin = 16'h0777; y_origin = 16'h0555; step = 16'h0011;
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        run_pixels(5, -1, 0);
        end_of_frame();

        // c_real wraps from 32767 to -32768.
        lat = 3;
        start_frame(16'h7FFF, 16'h0000, 16'h0001);
        run_pixels(8, -1, 0);
        end_of_frame();

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
